// File: rtl/fsm_experiment_seq_if.sv
// ---------------------------------------------------------------------------
// fsm_experiment_seq_if
//
// Bundles the front-panel inputs, the latched trigger configuration and the
// timing-core outputs of fsm_experiment_seq into one port. clock and
// reset_signal are not part of the bundle; they stay plain ports on the core.
//
// Signals
//   start_signal       arm request, rising edge starts a shot
//   abort_signal       rising edge aborts a running shot
//   fg_signal          FG opto input
//   wire_signal        wire-break input
//   phase_signal       phase reference input
//   detector_ready     detector ready level (low = busy)
//   trig_delay         per-channel delay after the phase edge, channel i = [i*CNT_W +: CNT_W]
//   trig_len           per-channel pulse length, 0 disables the channel
//   detonation_signal  detonation pulse
//   output_trigger     one trigger pulse per channel
//   scenario_state     {4'b0, state code}
//   counter_out        internal cycle counter
//   error_code         0 none, 1 wire timeout, 2 detector timeout, 3 abort
//
// Modports
//   master  the side that drives the front panel and watches the outputs
//   slave   the timing core itself
// ---------------------------------------------------------------------------
interface fsm_experiment_seq_if #(
    parameter int N_TRIG = 4,
    parameter int CNT_W  = 32
);
    logic                    start_signal;
    logic                    abort_signal;
    logic                    fg_signal;
    logic                    wire_signal;
    logic                    phase_signal;
    logic                    detector_ready;
    logic [N_TRIG*CNT_W-1:0] trig_delay;
    logic [N_TRIG*CNT_W-1:0] trig_len;

    logic                    detonation_signal;
    logic [N_TRIG-1:0]       output_trigger;
    logic [7:0]              scenario_state;
    logic [CNT_W-1:0]        counter_out;
    logic [1:0]              error_code;

    modport master (
        output start_signal, abort_signal, fg_signal, wire_signal, phase_signal,
               detector_ready, trig_delay, trig_len,
        input  detonation_signal, output_trigger, scenario_state, counter_out, error_code
    );

    modport slave (
        input  start_signal, abort_signal, fg_signal, wire_signal, phase_signal,
               detector_ready, trig_delay, trig_len,
        output detonation_signal, output_trigger, scenario_state, counter_out, error_code
    );
endinterface

// File: rtl/fsm_experiment_seq.sv
// ---------------------------------------------------------------------------
// fsm_experiment_seq
//
// Timing core between the front-panel inputs and the trigger fan-out. One
// shot runs: start edge -> FG opto edge -> fixed FG open delay -> detonation
// pulse -> wire break edge -> phase edge -> N_TRIG independently delayed and
// sized trigger pulses -> detector busy/ready supervision -> finished.
// A rising abort edge during a shot forces ERROR; timeouts are reported on
// error_code.
//
// Ports
//   clock          system clock
//   reset_signal   asynchronous reset, active-high
//   bus            fsm_experiment_seq_if.slave (front-panel inputs, trigger
//                  configuration, detonation/trigger outputs, state, counter,
//                  error code)
//
// Parameters
//   N_TRIG         number of trigger channels (1..8)
//   CNT_W          width of the counter and the per-channel delay/length fields
//   FG_OPEN_DELAY  cycles spent in FG_WAIT_OPEN (>= 1)
//   DETONATE_LEN   detonation_signal high time in cycles (>= 1)
//   DET_TIMEOUT    maximum cycles in DET_WAIT before a forced finish (>= 1)
//   WIRE_TIMEOUT   maximum cycles in WIRE_WAIT, only used with WIRE_TIMEOUT_EN
//
// Build option
//   WIRE_TIMEOUT_EN  when defined, WIRE_WAIT counts and gives up after
//                    WIRE_TIMEOUT cycles with error_code 1. When undefined
//                    WIRE_WAIT waits forever and error_code 1 never occurs.
// ---------------------------------------------------------------------------
module fsm_experiment_seq #(
    parameter int N_TRIG        = 4,
    parameter int CNT_W         = 32,
    parameter int FG_OPEN_DELAY = 400_000,
    parameter int DETONATE_LEN  = 200,
    parameter int DET_TIMEOUT   = 1_400_000,
    parameter int WIRE_TIMEOUT  = 2_000_000
) (
    input  logic                 clock,
    input  logic                 reset_signal,
    fsm_experiment_seq_if.slave  bus
);

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_FG_WAIT_OPTO = 4'd1,
        ST_FG_WAIT_OPEN = 4'd2,
        ST_DETONATE     = 4'd3,
        ST_WIRE_WAIT    = 4'd4,
        ST_PHASE_WAIT   = 4'd5,
        ST_TRIG_RUN     = 4'd6,
        ST_DET_BUSY     = 4'd7,
        ST_DET_WAIT     = 4'd8,
        ST_FINISHED     = 4'd9,
        ST_ERROR        = 4'd10
    } state_t;

    // Bit positions of the inputs inside the history vectors.
    localparam int IDX_START = 0;
    localparam int IDX_ABORT = 1;
    localparam int IDX_FG    = 2;
    localparam int IDX_WIRE  = 3;
    localparam int IDX_PHASE = 4;
    localparam int IDX_READY = 5;
    localparam int N_IN      = 6;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        counter;
    logic [CNT_W-1:0]        next_counter;
    logic [1:0]              err;
    logic [1:0]              next_err;
    logic                    latch_cfg;

    logic [N_IN-1:0]         in_now;
    logic [N_IN-1:0]         hist_new;
    logic [N_IN-1:0]         hist_old;

    logic                    start_rise;
    logic                    abort_rise;
    logic                    fg_rise;
    logic                    wire_rise;
    logic                    phase_rise;
    logic                    start_level;
    logic                    abort_level;
    logic                    ready_level;
    logic                    unused_ready_old;

    logic [N_TRIG*CNT_W-1:0] delay_q;
    logic [N_TRIG*CNT_W-1:0] len_q;
    logic [CNT_W:0]          trig_end [N_TRIG];
    logic [CNT_W:0]          max_end;
    logic                    trig_done;
    logic                    abortable;
    logic [N_TRIG-1:0]       trig;

    assign in_now = {bus.detector_ready, bus.phase_signal, bus.wire_signal,
                     bus.fg_signal, bus.abort_signal, bus.start_signal};

    // Two-flop history for every front-panel input. The FSM only ever looks
    // at these registered copies, so an input first seen high at one clock
    // causes its transition on the following clock.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            hist_new <= '0;
            hist_old <= '0;
        end else begin
            hist_new <= in_now;
            hist_old <= hist_new;
        end
    end

    // An edge is the history pattern old=0, new=1; levels use the newer flop.
    assign start_rise  = hist_new[IDX_START] & ~hist_old[IDX_START];
    assign abort_rise  = hist_new[IDX_ABORT] & ~hist_old[IDX_ABORT];
    assign fg_rise     = hist_new[IDX_FG]    & ~hist_old[IDX_FG];
    assign wire_rise   = hist_new[IDX_WIRE]  & ~hist_old[IDX_WIRE];
    assign phase_rise  = hist_new[IDX_PHASE] & ~hist_old[IDX_PHASE];
    assign start_level = hist_new[IDX_START];
    assign abort_level = hist_new[IDX_ABORT];
    assign ready_level = hist_new[IDX_READY];

    // detector_ready is only ever used as a level.
    assign unused_ready_old = hist_old[IDX_READY];

    // Trigger configuration is captured once at the start edge so that a
    // panel change mid-shot cannot move a pulse that is already scheduled.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            delay_q <= '0;
            len_q   <= '0;
        end else if (latch_cfg) begin
            delay_q <= bus.trig_delay;
            len_q   <= bus.trig_len;
        end
    end

    // Window end of every channel, one bit wider than the fields so that
    // delay + length cannot wrap. The run stops at the latest end among the
    // channels whose length is non-zero; with none enabled that is 0.
    always_comb begin
        max_end = '0;
        for (int i = 0; i < N_TRIG; i++) begin
            trig_end[i] = {1'b0, delay_q[i*CNT_W +: CNT_W]} + {1'b0, len_q[i*CNT_W +: CNT_W]};
            if ((len_q[i*CNT_W +: CNT_W] != '0) && (trig_end[i] > max_end)) begin
                max_end = trig_end[i];
            end
        end
    end

    // A window ending beyond the counter range is cut off when the counter
    // saturates rather than letting it wrap and re-open early windows.
    assign trig_done = ({1'b0, counter} >= max_end) || (&counter);

    assign abortable = !(state inside {ST_IDLE, ST_FINISHED, ST_ERROR});

    // State, counter and error code registers.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state   <= ST_IDLE;
            counter <= '0;
            err     <= 2'd0;
        end else begin
            state   <= next_state;
            counter <= next_counter;
            err     <= next_err;
        end
    end

    // Next-state logic. Every timed state enters with the counter at 0 and
    // leaves when the counter shows the last cycle of its interval, so a
    // state timed for N cycles is held for exactly N clocks. The abort check
    // comes last so that it overrides whatever the state itself decided.
    always_comb begin
        next_state   = state;
        next_counter = counter;
        next_err     = err;
        latch_cfg    = 1'b0;

        case (state)
            ST_IDLE: begin
                next_counter = '0;
                if (start_rise) begin
                    next_state = ST_FG_WAIT_OPTO;
                    next_err   = 2'd0;
                    latch_cfg  = 1'b1;
                end
            end

            ST_FG_WAIT_OPTO: begin
                if (fg_rise) begin
                    next_state   = ST_FG_WAIT_OPEN;
                    next_counter = '0;
                end
            end

            ST_FG_WAIT_OPEN: begin
                if (counter == CNT_W'(FG_OPEN_DELAY - 1)) begin
                    next_state   = ST_DETONATE;
                    next_counter = '0;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end

            ST_DETONATE: begin
                if (counter == CNT_W'(DETONATE_LEN - 1)) begin
                    next_state   = ST_WIRE_WAIT;
                    next_counter = '0;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end

            ST_WIRE_WAIT: begin
                if (wire_rise) begin
                    next_state   = ST_PHASE_WAIT;
                    next_counter = '0;
                end
`ifdef WIRE_TIMEOUT_EN
                else if (counter == CNT_W'(WIRE_TIMEOUT - 1)) begin
                    next_state   = ST_ERROR;
                    next_counter = '0;
                    next_err     = 2'd1;
                end else begin
                    next_counter = counter + 1'b1;
                end
`endif
            end

            ST_PHASE_WAIT: begin
                if (phase_rise) begin
                    next_state   = ST_TRIG_RUN;
                    next_counter = '0;
                end
            end

            ST_TRIG_RUN: begin
                if (trig_done) begin
                    next_state   = ST_DET_BUSY;
                    next_counter = '0;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end

            ST_DET_BUSY: begin
                if (!ready_level) begin
                    next_state   = ST_DET_WAIT;
                    next_counter = '0;
                end
            end

            ST_DET_WAIT: begin
                if (ready_level) begin
                    next_state   = ST_FINISHED;
                    next_counter = '0;
                end else if (counter == CNT_W'(DET_TIMEOUT - 1)) begin
                    next_state   = ST_FINISHED;
                    next_counter = '0;
                    next_err     = 2'd2;
                end else begin
                    next_counter = counter + 1'b1;
                end
            end

            ST_FINISHED: begin
                // Waiting for start to drop prevents a held button re-firing.
                if (!start_level) begin
                    next_state   = ST_IDLE;
                    next_counter = '0;
                end
            end

            ST_ERROR: begin
                next_counter = '0;
                if (!start_level && !abort_level) begin
                    next_state = ST_IDLE;
                end
            end

            default: begin
                next_state   = ST_IDLE;
                next_counter = '0;
            end
        endcase

        if (abortable && abort_rise) begin
            next_state   = ST_ERROR;
            next_counter = '0;
            next_err     = 2'd3;
            latch_cfg    = 1'b0;
        end
    end

    // Trigger pulses are decoded straight from the state and counter, so a
    // reset or an abort silences them in the same cycle the state changes.
    always_comb begin
        trig = '0;
        if (state == ST_TRIG_RUN) begin
            for (int i = 0; i < N_TRIG; i++) begin
                trig[i] = ({1'b0, counter} >= {1'b0, delay_q[i*CNT_W +: CNT_W]}) &&
                          ({1'b0, counter} < trig_end[i]);
            end
        end
    end

`ifndef WIRE_TIMEOUT_EN
    logic unused_wire_timeout;
    assign unused_wire_timeout = (WIRE_TIMEOUT != 0);
`endif

    assign bus.detonation_signal = (state == ST_DETONATE);
    assign bus.output_trigger    = trig;
    assign bus.scenario_state    = {4'b0000, state};
    assign bus.counter_out       = counter;
    assign bus.error_code        = err;

endmodule

// File: tb/tb_fsm_experiment_seq.sv
// ---------------------------------------------------------------------------
// tb_fsm_experiment_seq
//
// Drives fsm_experiment_seq through directed and randomised shots. Expected
// trigger waveforms come from the window rule "channel i is high while the
// run count lies in [delay_i, delay_i + len_i)", and expected state timing
// from the fixed state durations plus the two-clock input latency.
// Honours WIRE_TIMEOUT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_fsm_experiment_seq;

    localparam int N_TRIG        = 2;
    localparam int CNT_W         = 16;
    localparam int FG_OPEN_DELAY = 10;
    localparam int DETONATE_LEN  = 4;
    localparam int DET_TIMEOUT   = 50;
    localparam int WIRE_TIMEOUT  = 20;

    logic clock = 1'b0;
    logic reset_signal;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    fsm_experiment_seq_if #(.N_TRIG(N_TRIG), .CNT_W(CNT_W)) bus ();

    fsm_experiment_seq #(
        .N_TRIG(N_TRIG), .CNT_W(CNT_W), .FG_OPEN_DELAY(FG_OPEN_DELAY),
        .DETONATE_LEN(DETONATE_LEN), .DET_TIMEOUT(DET_TIMEOUT), .WIRE_TIMEOUT(WIRE_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_signal(reset_signal),
        .bus(bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_config(input int d0, input int d1, input int l0, input int l1);
        bus.trig_delay = {CNT_W'(d1), CNT_W'(d0)};
        bus.trig_len   = {CNT_W'(l1), CNT_W'(l0)};
    endtask

    task automatic clear_inputs();
        bus.start_signal   = 1'b0;
        bus.abort_signal   = 1'b0;
        bus.fg_signal      = 1'b0;
        bus.wire_signal    = 1'b0;
        bus.phase_signal   = 1'b0;
        bus.detector_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_signal = 1'b1;
        clear_inputs();
        set_config(0, 0, 0, 0);
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0 || bus.counter_out !== '0 || bus.error_code !== 2'd0 ||
            bus.detonation_signal !== 1'b0 || bus.output_trigger !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_values: got state=%0d cnt=%0d err=%0d det=%b trig=%b, expected all 0",
                     bus.scenario_state, bus.counter_out, bus.error_code, bus.detonation_signal, bus.output_trigger);
        end
        reset_signal = 1'b0;
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: got state=%0d, expected 0", bus.scenario_state);
        end
    endtask

    // Runs a shot from IDLE up to DET_BUSY and checks every cycle on the way.
    task automatic test_fire_sequence(input int d0, input int d1, input int l0, input int l1);
        int dl[2];
        int ln[2];
        int max_end;
        logic [1:0] exp_trig;
        dl[0] = d0; dl[1] = d1; ln[0] = l0; ln[1] = l1;
        max_end = 0;
        for (int i = 0; i < 2; i++)
            if (ln[i] > 0 && dl[i] + ln[i] > max_end) max_end = dl[i] + ln[i];

        set_config(d0, d1, l0, l1);
        bus.start_signal = 1'b1;
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL start_latency: got state=%0d, expected 0", bus.scenario_state);
        end
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd1 || bus.error_code !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL start_edge: got state=%0d err=%0d, expected state=1 err=0",
                     bus.scenario_state, bus.error_code);
        end
        // The shot must keep the configuration captured at the start edge.
        bus.trig_delay = $urandom;
        bus.trig_len   = $urandom;

        bus.fg_signal = 1'b1;
        tick();
        tick();
        for (int k = 0; k < FG_OPEN_DELAY; k++) begin
            n_compared++;
            if (bus.scenario_state !== 8'd2 || bus.counter_out !== CNT_W'(k) || bus.detonation_signal !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL fg_open k=%0d: got state=%0d cnt=%0d det=%b, expected state=2 cnt=%0d det=0",
                         k, bus.scenario_state, bus.counter_out, bus.detonation_signal, k);
            end
            tick();
        end
        for (int k = 0; k < DETONATE_LEN; k++) begin
            n_compared++;
            if (bus.scenario_state !== 8'd3 || bus.counter_out !== CNT_W'(k) || bus.detonation_signal !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL detonate k=%0d: got state=%0d cnt=%0d det=%b, expected state=3 cnt=%0d det=1",
                         k, bus.scenario_state, bus.counter_out, bus.detonation_signal, k);
            end
            tick();
        end
        n_compared++;
        if (bus.scenario_state !== 8'd4 || bus.detonation_signal !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL wire_wait_entry: got state=%0d det=%b, expected state=4 det=0",
                     bus.scenario_state, bus.detonation_signal);
        end

        bus.wire_signal = 1'b1;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL wire_edge: got state=%0d, expected 5", bus.scenario_state);
        end
        bus.phase_signal = 1'b1;
        tick();
        tick();
        for (int c = 0; c <= max_end; c++) begin
            for (int i = 0; i < 2; i++) exp_trig[i] = (c >= dl[i]) && (c < dl[i] + ln[i]);
            n_compared++;
            if (bus.scenario_state !== 8'd6 || bus.counter_out !== CNT_W'(c) || bus.output_trigger !== exp_trig) begin
                n_mismatched++;
                $display("[TB] FAIL trig_run c=%0d: got state=%0d cnt=%0d trig=%b, expected state=6 cnt=%0d trig=%b",
                         c, bus.scenario_state, bus.counter_out, bus.output_trigger, c, exp_trig);
            end
            tick();
        end
        n_compared++;
        if (bus.scenario_state !== 8'd7 || bus.output_trigger !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL trig_exit: got state=%0d trig=%b, expected state=7 trig=00",
                     bus.scenario_state, bus.output_trigger);
        end
        bus.fg_signal    = 1'b0;
        bus.wire_signal  = 1'b0;
        bus.phase_signal = 1'b0;
    endtask

    // From DET_BUSY: detector goes busy, becomes ready after w cycles.
    task automatic test_detector_ready(input int w);
        bus.detector_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < w; k++) begin
            n_compared++;
            if (bus.scenario_state !== 8'd8 || bus.counter_out !== CNT_W'(k)) begin
                n_mismatched++;
                $display("[TB] FAIL det_wait k=%0d: got state=%0d cnt=%0d, expected state=8 cnt=%0d",
                         k, bus.scenario_state, bus.counter_out, k);
            end
            tick();
        end
        bus.detector_ready = 1'b1;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd9 || bus.error_code !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL det_ready_finish: got state=%0d err=%0d, expected state=9 err=0",
                     bus.scenario_state, bus.error_code);
        end
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd9) begin
            n_mismatched++;
            $display("[TB] FAIL finished_hold: got state=%0d, expected 9 while start held", bus.scenario_state);
        end
        bus.start_signal = 1'b0;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0 || bus.error_code !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL finished_to_idle: got state=%0d err=%0d, expected state=0 err=0",
                     bus.scenario_state, bus.error_code);
        end
    endtask

    // From DET_BUSY: detector never becomes ready again.
    task automatic test_detector_timeout();
        bus.detector_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < DET_TIMEOUT; k++) begin
            n_compared++;
            if (bus.scenario_state !== 8'd8 || bus.counter_out !== CNT_W'(k)) begin
                n_mismatched++;
                $display("[TB] FAIL det_timeout_wait k=%0d: got state=%0d cnt=%0d, expected state=8 cnt=%0d",
                         k, bus.scenario_state, bus.counter_out, k);
            end
            tick();
        end
        n_compared++;
        if (bus.scenario_state !== 8'd9 || bus.error_code !== 2'd2) begin
            n_mismatched++;
            $display("[TB] FAIL det_timeout: got state=%0d err=%0d, expected state=9 err=2",
                     bus.scenario_state, bus.error_code);
        end
        bus.detector_ready = 1'b1;
        bus.start_signal   = 1'b0;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0 || bus.error_code !== 2'd2) begin
            n_mismatched++;
            $display("[TB] FAIL det_timeout_idle: got state=%0d err=%0d, expected state=0 err=2",
                     bus.scenario_state, bus.error_code);
        end
    endtask

    task automatic test_abort();
        bus.start_signal = 1'b1;
        tick();
        tick();
        bus.fg_signal = 1'b1;
        tick();
        tick();
        repeat (FG_OPEN_DELAY) tick();
        tick();
        bus.abort_signal = 1'b1;
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd3 || bus.detonation_signal !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL abort_latency: got state=%0d det=%b, expected state=3 det=1",
                     bus.scenario_state, bus.detonation_signal);
        end
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd10 || bus.detonation_signal !== 1'b0 || bus.error_code !== 2'd3 ||
            bus.output_trigger !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL abort_error: got state=%0d det=%b err=%0d trig=%b, expected state=10 det=0 err=3 trig=00",
                     bus.scenario_state, bus.detonation_signal, bus.error_code, bus.output_trigger);
        end
        bus.abort_signal = 1'b0;
        tick();
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd10) begin
            n_mismatched++;
            $display("[TB] FAIL error_hold_start: got state=%0d, expected 10 while start high", bus.scenario_state);
        end
        bus.start_signal = 1'b0;
        bus.fg_signal    = 1'b0;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0 || bus.error_code !== 2'd3) begin
            n_mismatched++;
            $display("[TB] FAIL error_to_idle: got state=%0d err=%0d, expected state=0 err=3",
                     bus.scenario_state, bus.error_code);
        end
    endtask

    task automatic test_wire_timeout();
        int exp_cnt;
        bus.start_signal = 1'b1;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd1 || bus.error_code !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL error_clear_on_start: got state=%0d err=%0d, expected state=1 err=0",
                     bus.scenario_state, bus.error_code);
        end
        bus.fg_signal = 1'b1;
        tick();
        tick();
        repeat (FG_OPEN_DELAY + DETONATE_LEN) tick();
        for (int k = 0; k < WIRE_TIMEOUT; k++) begin
`ifdef WIRE_TIMEOUT_EN
            exp_cnt = k;
`else
            exp_cnt = 0;
`endif
            n_compared++;
            if (bus.scenario_state !== 8'd4 || bus.counter_out !== CNT_W'(exp_cnt)) begin
                n_mismatched++;
                $display("[TB] FAIL wire_wait k=%0d: got state=%0d cnt=%0d, expected state=4 cnt=%0d",
                         k, bus.scenario_state, bus.counter_out, exp_cnt);
            end
            tick();
        end
`ifdef WIRE_TIMEOUT_EN
        n_compared++;
        if (bus.scenario_state !== 8'd10 || bus.error_code !== 2'd1) begin
            n_mismatched++;
            $display("[TB] FAIL wire_timeout: got state=%0d err=%0d, expected state=10 err=1",
                     bus.scenario_state, bus.error_code);
        end
`else
        n_compared++;
        if (bus.scenario_state !== 8'd4 || bus.error_code !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL wire_no_timeout: got state=%0d err=%0d, expected state=4 err=0",
                     bus.scenario_state, bus.error_code);
        end
        bus.abort_signal = 1'b1;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd10 || bus.error_code !== 2'd3) begin
            n_mismatched++;
            $display("[TB] FAIL wire_abort: got state=%0d err=%0d, expected state=10 err=3",
                     bus.scenario_state, bus.error_code);
        end
`endif
        bus.abort_signal = 1'b0;
        bus.start_signal = 1'b0;
        bus.fg_signal    = 1'b0;
        tick();
        tick();
        n_compared++;
        if (bus.scenario_state !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL wire_cleanup_idle: got state=%0d, expected 0", bus.scenario_state);
        end
    endtask

    task automatic test_reset_mid_shot();
        logic [1:0] exp_trig;
        set_config(0, 2, 10, 3);
        bus.start_signal = 1'b1;
        tick();
        tick();
        bus.fg_signal = 1'b1;
        tick();
        tick();
        repeat (FG_OPEN_DELAY + DETONATE_LEN) tick();
        bus.wire_signal = 1'b1;
        tick();
        tick();
        bus.phase_signal = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        exp_trig[0] = (3 >= 0) && (3 < 0 + 10);
        exp_trig[1] = (3 >= 2) && (3 < 2 + 3);
        n_compared++;
        if (bus.scenario_state !== 8'd6 || bus.output_trigger !== exp_trig) begin
            n_mismatched++;
            $display("[TB] FAIL pre_reset_trig: got state=%0d trig=%b, expected state=6 trig=%b",
                     bus.scenario_state, bus.output_trigger, exp_trig);
        end
        reset_signal = 1'b1;
        #1;
        n_compared++;
        if (bus.output_trigger !== 2'b00 || bus.scenario_state !== 8'd0 || bus.counter_out !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_shot: got state=%0d cnt=%0d trig=%b, expected state=0 cnt=0 trig=00",
                     bus.scenario_state, bus.counter_out, bus.output_trigger);
        end
        clear_inputs();
        tick();
        tick();
        reset_signal = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_compared++;
            if (bus.output_trigger !== 2'b00 || bus.detonation_signal !== 1'b0 || bus.scenario_state !== 8'd0) begin
                n_mismatched++;
                $display("[TB] FAIL after_reset k=%0d: got state=%0d trig=%b det=%b, expected state=0 trig=00 det=0",
                         k, bus.scenario_state, bus.output_trigger, bus.detonation_signal);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            test_fire_sequence($urandom_range(0, 8), $urandom_range(0, 8),
                               $urandom_range(0, 8), $urandom_range(0, 8));
            test_detector_ready($urandom_range(0, 30));
        end
    endtask

    initial begin
        $display("[TB] starting fsm_experiment_seq bench");
        test_reset();
        test_fire_sequence(3, 0, 2, 5);
        test_detector_ready(8);
        test_fire_sequence($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 6), $urandom_range(0, 6));
        test_detector_timeout();
        test_abort();
        test_wire_timeout();
        test_reset_mid_shot();
        test_fire_sequence(3, 5, 0, 0);
        test_detector_ready(2);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
